// File: rtl/add_32bit_unsigned_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_32bit_unsigned_seq
// Brief    : Multi-cycle unsigned adder, one CHUNK_W slice per clock with a
//            registered ripple carry; define ADD_SAT_EN to saturate on carry.
// Revision : 1.0
// ============================================================================
module add_32bit_unsigned_seq #(
   parameter int WIDTH   = 32,
   parameter int CHUNK_W = 8    // WIDTH must be a multiple of CHUNK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int N     = WIDTH / CHUNK_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               cin_q, cin_d;
   logic               carry_q, carry_d;

   logic [CHUNK_W-1:0] a_slice;
   logic [CHUNK_W-1:0] b_slice;
   logic [CHUNK_W:0]   slice_sum;

   // Operand slice mux: constant-index selects keep every part-select static.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_slice = a_q[k*CHUNK_W +: CHUNK_W];
            b_slice = b_q[k*CHUNK_W +: CHUNK_W];
         end
      end
   end

   assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK_W{1'b0}}, cin_q};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      idx_d    = idx_q;
      cin_d    = cin_q;
      carry_d  = carry_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_d     = A;
               b_d     = B;
               idx_d   = '0;
               cin_d   = 1'b0;
               carry_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            for (int k = 0; k < N; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  result_d[k*CHUNK_W +: CHUNK_W] = slice_sum[CHUNK_W-1:0];
               end
            end
            if (idx_q == LAST_IDX) begin
               carry_d = slice_sum[CHUNK_W];
               state_d = DONE;
`ifdef ADD_SAT_EN
               if (slice_sum[CHUNK_W]) begin
                  result_d = '1;
               end
`endif
            end else begin
               idx_d = idx_q + IDX_W'(1);
               cin_d = slice_sum[CHUNK_W];
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         idx_q    <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         cin_q    <= cin_d;
         carry_q  <= carry_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign carry  = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_add_32bit_unsigned_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_32bit_unsigned_seq
// Brief    : Directed and random bench for three slice widths (8, 4, 32 bits)
//            sharing one stimulus stream, each with its own scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_add_32bit_unsigned_seq;

   localparam int WIDTH = 32;
`ifdef ADD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   logic             d8_busy, d8_done, d8_carry;
   logic [WIDTH-1:0] d8_result;
   logic             d4_busy, d4_done, d4_carry;
   logic [WIDTH-1:0] d4_result;
   logic             d32_busy, d32_done, d32_carry;
   logic [WIDTH-1:0] d32_result;

   int n_vec = 0;
   int n_err = 0;

   logic [32:0] q8[$];
   logic [32:0] q4[$];
   logic [32:0] q32[$];
   logic [32:0] e8, e4, e32;

   add_32bit_unsigned_seq #(.WIDTH(WIDTH), .CHUNK_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
      .busy(d8_busy), .done(d8_done), .result(d8_result), .carry(d8_carry)
   );

   add_32bit_unsigned_seq #(.WIDTH(WIDTH), .CHUNK_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
      .busy(d4_busy), .done(d4_done), .result(d4_result), .carry(d4_carry)
   );

   add_32bit_unsigned_seq #(.WIDTH(WIDTH), .CHUNK_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
      .busy(d32_busy), .done(d32_done), .result(d32_result), .carry(d32_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain 33-bit sum, top bit is carry-out.
   function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
      logic [32:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (SAT && s[32]) s[31:0] = 32'hFFFF_FFFF;
      return s;
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h00FF_00FF;
         3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboards: inputs are driven just after the rising edge, so at the
   // falling edge start/busy show exactly what the next edge will see.
   always @(negedge clk) begin
      if (!rst_n) begin
         q8.delete();
      end else begin
         if (d8_done) begin
            if (q8.size() == 0) check_value("n8_spurious_done", 64'(d8_done), 64'd0);
            else begin
               e8 = q8.pop_front();
               check_value("n8_result", 64'(d8_result), 64'(e8[31:0]));
               check_value("n8_carry", 64'(d8_carry), 64'(e8[32]));
            end
         end
         if (start && !d8_busy) q8.push_back(ref_sum(a, b));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q4.delete();
      end else begin
         if (d4_done) begin
            if (q4.size() == 0) check_value("n4_spurious_done", 64'(d4_done), 64'd0);
            else begin
               e4 = q4.pop_front();
               check_value("n4_result", 64'(d4_result), 64'(e4[31:0]));
               check_value("n4_carry", 64'(d4_carry), 64'(e4[32]));
            end
         end
         if (start && !d4_busy) q4.push_back(ref_sum(a, b));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q32.delete();
      end else begin
         if (d32_done) begin
            if (q32.size() == 0) check_value("n32_spurious_done", 64'(d32_done), 64'd0);
            else begin
               e32 = q32.pop_front();
               check_value("n32_result", 64'(d32_result), 64'(e32[31:0]));
               check_value("n32_carry", 64'(d32_carry), 64'(e32[32]));
            end
         end
         if (start && !d32_busy) q32.push_back(ref_sum(a, b));
      end
   end

   // One-cycle start pulse; returns one step after the accepting edge.
   task automatic launch(input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (!d8_done && lat < 40) begin
         if (d8_busy) bc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er, input logic ec);
      int lat, bc;
      launch(x, y);
      wait_done(lat, bc);
      check_value({tag, "_latency"}, 64'(lat), 64'd4);
      check_value({tag, "_busy_cycles"}, 64'(bc), 64'd4);
      check_value({tag, "_busy_in_done"}, 64'(d8_busy), 64'd0);
      check_value({tag, "_result"}, 64'(d8_result), 64'(er));
      check_value({tag, "_carry"}, 64'(d8_carry), 64'(ec));
   endtask

   initial begin
      int lat, bc;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_busy", 64'(d8_busy), 64'd0);
      check_value("rst_done", 64'(d8_done), 64'd0);
      check_value("rst_result", 64'(d8_result), 64'd0);
      check_value("rst_carry", 64'(d8_carry), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      directed("big", 32'd3000000000, 32'd1000000000, 32'hEE6B_2800, 1'b0);
      directed("chain", 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0);
      directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, SAT ? 32'hFFFF_FFFF : 32'h0, 1'b1);
      directed("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, 1'b1);
      directed("zero", 32'h0, 32'h0, 32'h0, 1'b0);

      // Back-to-back: start asserted during the done cycle.
      directed("pre_b2b", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
      a = 32'd5; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_value("b2b_busy", 64'(d8_busy), 64'd1);
      wait_done(lat, bc);
      check_value("b2b_latency", 64'(lat), 64'd4);
      check_value("b2b_result", 64'(d8_result), 64'd12);
      check_value("b2b_carry", 64'(d8_carry), 64'd0);

      // Start with new operands two cycles into a run must be ignored.
      launch(32'd3000000000, 32'd1000000000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
      wait_done(lat, bc);
      check_value("ign_latency", 64'(lat), 64'd1);
      check_value("ign_result", 64'(d8_result), 64'hEE6B_2800);
      check_value("ign_carry", 64'(d8_carry), 64'd0);
      repeat (10) @(posedge clk);
      #1;

      // Make result/carry non-zero, then abort a run with reset.
      directed("pre_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, 1'b1);
      launch(32'h1234_5678, 32'h9ABC_DEF0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_value("abort_busy", 64'(d8_busy), 64'd0);
      check_value("abort_done", 64'(d8_done), 64'd0);
      check_value("abort_result", 64'(d8_result), 64'd0);
      check_value("abort_carry", 64'(d8_carry), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_value("post_rst_done", 64'(d8_done), 64'd0);
      directed("post_rst", 32'h8000_0000, 32'h8000_0001, SAT ? 32'hFFFF_FFFF : 32'h1, 1'b1);
      repeat (10) @(posedge clk);
      #1;

      // Random back-to-back traffic with start held high.
      start = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         a = rnd_operand();
         b = rnd_operand();
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_value("n8_drain", 64'(q8.size()), 64'd0);
      check_value("n4_drain", 64'(q4.size()), 64'd0);
      check_value("n32_drain", 64'(q32.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
